aes_iter_core: RTL

AES_ITER_CORE -- requirements
Module: aes_iter_core

---
 rtl/aes_iter_core.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: on-chip key expansion, one round per clock, single block in flight.
// Define AES_ITER_CTR_EN to build the counter-mode variant (adds iv_load/iv ports).
module aes_iter_core #(
  parameter int KEY_BITS = 192
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_BITS-1:0] key,
  input  logic                key_load,
  output logic                key_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
`ifdef AES_ITER_CTR_EN
  input  logic                iv_load,
  input  logic [127:0]        iv,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK6   = 6'(NK);
  localparam logic [5:0] LASTW = 6'(NW - 1);
  localparam logic [3:0] NR4   = 4'(NR);
  localparam logic [2:0] JLAST = 3'(NK - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEYEXP = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // SubBytes+ShiftRows fused via index remap; MixColumns skipped on the final round.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned rw = 0; rw < 4; rw++)
        t[4*c+rw] = sb(s[127-8*(4*((c+rw)%4)+rw) -: 8]);
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (last) r[127-32*c -: 32] = {a0, a1, a2, a3};
      else      r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  logic [31:0]  rk_q [NW];
  logic [2:0]   state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [5:0]   idx_q, idx_d;
  logic [2:0]   jj_q, jj_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] out_q, out_d;
  logic         ovalid_q, ovalid_d;
  logic         kready_q, kready_d;
  logic [127:0] src_blk;
`ifdef AES_ITER_CTR_EN
  logic [127:0] ctr_q, ctr_d;
  logic [127:0] din_q, din_d;
`endif

  logic         hs, key_acc;
  logic [5:0]   rbase;
  logic [127:0] rkey, rnext;
  logic [31:0]  wprev, temp, wnew;

  // A block handshake in READY wins over a simultaneous key_load.
  assign hs      = in_valid && (state_q == S_READY);
  assign key_acc = key_load && ((state_q == S_IDLE) || ((state_q == S_READY) && !in_valid));
  assign rbase   = {round_q, 2'b00};
  assign rkey    = {rk_q[rbase], rk_q[rbase + 6'd1], rk_q[rbase + 6'd2], rk_q[rbase + 6'd3]};
  assign rnext   = aes_round(blk_q, round_q == NR4) ^ rkey;
  assign wprev   = rk_q[idx_q - 6'd1];
  assign wnew    = rk_q[idx_q - NK6] ^ temp;
`ifdef AES_ITER_CTR_EN
  assign src_blk = ctr_q;
`else
  assign src_blk = in_data;
`endif

  always_comb begin
    temp = wprev;
    if (jj_q == 3'd0)
      temp = sub_word({wprev[23:0], wprev[31:24]}) ^ {rcon_q, 24'h0};
    else if (NK > 6 && jj_q == 3'd4)
      temp = sub_word(wprev);
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    idx_d    = idx_q;
    jj_d     = jj_q;
    rcon_d   = rcon_q;
    blk_d    = blk_q;
    out_d    = out_q;
    ovalid_d = ovalid_q;
    kready_d = kready_q;
`ifdef AES_ITER_CTR_EN
    ctr_d    = ctr_q;
    din_d    = din_q;
`endif
    case (state_q)
      S_KEYEXP: begin
        idx_d = idx_q + 6'd1;
        jj_d  = (jj_q == JLAST) ? 3'd0 : jj_q + 3'd1;
        if (jj_q == 3'd0) rcon_d = xt(rcon_q);
        if (idx_q == LASTW) begin
          kready_d = 1'b1;
          state_d  = S_READY;
        end
      end
      S_READY: begin
`ifdef AES_ITER_CTR_EN
        if (iv_load) ctr_d = iv;
        if (hs) din_d = in_data;
`endif
        if (hs) begin
          blk_d   = src_blk ^ rkey;
          round_d = 4'd1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        blk_d   = rnext;
        round_d = round_q + 4'd1;
        if (round_q == NR4) begin
          round_d  = '0;
          ovalid_d = 1'b1;
          state_d  = S_HOLD;
`ifdef AES_ITER_CTR_EN
          out_d    = rnext ^ din_q;
`else
          out_d    = rnext;
`endif
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          out_d    = '0;
          state_d  = S_READY;
`ifdef AES_ITER_CTR_EN
          ctr_d[31:0] = ctr_q[31:0] + 32'd1;
`endif
        end
      end
      S_IDLE:  ;
      default: state_d = S_IDLE;
    endcase
    if (key_acc) begin
      state_d  = S_KEYEXP;
      kready_d = 1'b0;
      idx_d    = NK6;
      jj_d     = '0;
      rcon_d   = 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      round_q  <= '0;
      idx_q    <= '0;
      jj_q     <= '0;
      rcon_q   <= '0;
      blk_q    <= '0;
      out_q    <= '0;
      ovalid_q <= 1'b0;
      kready_q <= 1'b0;
`ifdef AES_ITER_CTR_EN
      ctr_q    <= '0;
      din_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      idx_q    <= idx_d;
      jj_q     <= jj_d;
      rcon_q   <= rcon_d;
      blk_q    <= blk_d;
      out_q    <= out_d;
      ovalid_q <= ovalid_d;
      kready_q <= kready_d;
`ifdef AES_ITER_CTR_EN
      ctr_q    <= ctr_d;
      din_q    <= din_d;
`endif
    end
  end

  // Round-key store is never reset; key_ready alone marks it valid.
  always_ff @(posedge clk) begin
    if (key_acc) begin
      for (int unsigned k = 0; k < NK; k++)
        rk_q[k] <= key[KEY_BITS-1-32*k -: 32];
    end else if (state_q == S_KEYEXP) begin
      rk_q[idx_q] <= wnew;
    end
  end

  assign key_ready = kready_q;
  assign in_ready  = (state_q == S_READY);
  assign out_valid = ovalid_q;
  assign out_data  = out_q;

endmodule
